// File: rtl/quadrilatero_lsu_row_sequencer.sv
// Turns one LSU instruction into per-row OBI req/gnt/rvalid transactions.
// Optional stall counter port: define QUADRILATERO_LSU_SEQ_PERF_EN.
module quadrilatero_lsu_row_sequencer #(
    parameter  int ADDR_W          = 32,
    parameter  int MAX_ROWS        = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int RW              = $clog2(MAX_ROWS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [RW-1:0]     n_rows_i,
    input  logic              is_store_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [RW-1:0]     req_row_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
`ifdef QUADRILATERO_LSU_SEQ_PERF_EN
    output logic [31:0]       perf_stall_cnt_o,
`endif
    output logic              resp_valid_o,
    output logic [RW-1:0]     resp_row_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [RW-1:0]     r_n_rows;
    logic              r_we;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     r_resp_cnt;
    logic [RW-1:0]     r_resp_row;
    logic              r_resp_valid;
    logic [OW-1:0]     r_outst;

    logic              w_req;
    logic              w_gnt;
    logic              w_rv;
    logic              w_last;
    logic [OW-1:0]     w_outst_nxt;

    // Request depends only on registered state, so it stays up until granted.
    always_comb begin
        w_req  = (r_state == S_ISSUE) && (r_outst < MAX_O);
        w_gnt  = w_req && mem_gnt_i;
        w_rv   = mem_rvalid_i && (r_outst != '0);
        w_last = (r_row + RW'(1)) == r_n_rows;
        w_outst_nxt = r_outst;
        if (w_gnt && !w_rv) begin
            w_outst_nxt = r_outst + OW'(1);
        end else if (!w_gnt && w_rv) begin
            w_outst_nxt = r_outst - OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_stride     <= '0;
            r_n_rows     <= '0;
            r_we         <= 1'b0;
            r_row        <= '0;
            r_resp_cnt   <= '0;
            r_resp_row   <= '0;
            r_resp_valid <= 1'b0;
            r_outst      <= '0;
        end else begin
            r_resp_valid <= w_rv;
            r_outst      <= w_outst_nxt;
            if (w_rv) begin
                r_resp_row <= r_resp_cnt;
                r_resp_cnt <= r_resp_cnt + RW'(1);
            end
            if (w_gnt) begin
                r_row  <= r_row + RW'(1);
                r_addr <= r_addr + r_stride;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr     <= base_addr_i;
                        r_stride   <= stride_i;
                        r_n_rows   <= n_rows_i;
                        r_we       <= is_store_i;
                        r_row      <= '0;
                        r_resp_cnt <= '0;
                        r_state    <= (n_rows_i == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_gnt && w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_outst_nxt == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef QUADRILATERO_LSU_SEQ_PERF_EN
    logic [31:0] r_perf;
    logic        w_stall;

    // Waiting on the memory and waiting on the outstanding limit both count.
    assign w_stall = (w_req && !mem_gnt_i) || ((r_state == S_ISSUE) && !w_req);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_perf <= '0;
        end else if (w_stall && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf;
`endif

    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign mem_req_o    = w_req;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign req_row_o    = r_row;
    assign resp_valid_o = r_resp_valid;
    assign resp_row_o   = r_resp_row;

endmodule
